dfp96_pack_seq: RTL and testbench
=================================

DFP96_PACK_SEQ -- requirements
Module: dfp96_pack_seq

Interface
REQ-001 SHALL have parameter NDECL, default 8, meaning the number of 10-bit declets in the coefficient continuation field; it is fixed at 8 for DFP96.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port ce, input, 1 bit: clock enable; when low, all state is held.
REQ-005 SHALL have port i_valid, input, 1 bit: input operand is present.
REQ-006 SHALL have port i_ready, output, 1 bit: the block accepts an operand.
REQ-007 SHALL have port i_sign, input, 1 bit: sign.
REQ-008 SHALL have port i_exp, input, 12 bits: biased exponent.
REQ-009 SHALL have port i_sig, input, 100 bits: 25 BCD digits, where digit 24 is bits [99:96].
REQ-010 SHALL have ports i_nan, i_snan and i_inf, each input, 1 bit: special-value flags.
REQ-011 SHALL have port o_valid, output, 1 bit: a packed result is available.
REQ-012 SHALL have port o_ready, input, 1 bit: the consumer accepts the result.
REQ-013 SHALL have port o, output, 96 bits: the DFP96 DPD-encoded result.
REQ-014 SHALL have port o_err, output, 1 bit: an invalid BCD digit or an exponent out of range was seen in this transaction.

Function
REQ-015 SHALL implement an FSM with states IDLE, CONV and DONE; i_ready = (state==IDLE).
REQ-016 SHALL, in IDLE with ce and i_valid both high, register all inputs, clear the declet counter k to 0, clear the error flag, and go to CONV.
REQ-017 SHALL, in CONV on each ce cycle, encode BCD digits 3k+2..3k into IEEE 754-2008 DPD and write the result to o[10k+9:10k], then increment k.
REQ-018 SHALL, after the k=7 encode, go to DONE and set o_valid=1. Latency is 9 ce-qualified edges from acceptance to o_valid.
REQ-019 SHALL, on the same edge as the CONV-to-DONE transition, write o[95]=sign, o[94:90]=combination field and o[89:80]=i_exp[9:0].
REQ-020 SHALL form the combination field as follows:
- Leading digit d24 in 0-7: {exp[11:10], d24[2:0]}.
- d24 of 8 or 9: {2'b11, exp[11:10], d24[0]}.
REQ-021 SHALL, in DONE, hold o, o_valid and o_err stable until o_ready is high with ce high, then clear o_valid and go to IDLE. There is no same-cycle re-accept.
REQ-022 SHALL stall every state and counter when ce is low; o_valid and o remain stable.
REQ-023 SHALL apply special values with priority NaN > infinity > range check:
- NaN: combination = 11111, o[89] = snan, o[88:80] = 0, coefficient continuation = normally encoded digits 23..0.
- Infinity: combination = 11110, o[89:0] = 0.
REQ-024 SHALL, for a non-special operand with exp[11:10]==2'b11, set o_err and produce a signed infinity encoding.
REQ-025 SHALL treat any nybble greater than 9 as 9 and set o_err; o_err is sticky until the next acceptance.
REQ-026 SHALL take 9 cycles for every operand class (uniform latency).
REQ-027 SHALL hold the inputs registered at acceptance, so input changes during CONV or DONE have no effect.

Reset
REQ-028 SHALL, on rst high at a clock edge (regardless of ce), go to IDLE and clear o_valid, o_err, o and k; i_ready is 1 on the next cycle.
REQ-029 SHALL, on rst during CONV or DONE, abort the transaction; no o_valid follows for that operand.

Verification
REQ-030 Zero: sign 0, exp 0, sig 0 -> o=96'h0, o_err=0, o_valid exactly 9 ce-edges after acceptance.
REQ-031 One and 999: sig=...001, exp 0 -> o=96'h000000000000000000000001; sig low digits 999 -> o[9:0]=10'h0FF.
REQ-032 Leading 9: d24=9, exp 12'h400, other digits 0 -> o=96'h6C0000000000000000000000; neg infinity -> o=96'hF80000000000000000000000.
REQ-033 Errors: nybble 4'hA in digit 0 -> o_err=1 and o[9:0] as for digit 9; exp 12'hC05 non-special -> o_err=1 and infinity encoding.
REQ-034 Backpressure and ce: hold o_ready=0 for 5 cycles in DONE -> o stable, i_ready=0. Toggle ce low mid-CONV -> latency extends by the number of low cycles.
REQ-035 Reset mid-CONV at k=4 -> next cycle i_ready=1, o_valid=0, o=0; a following operand completes correctly.

Source files
------------

// File: rtl/dfp96_pack_seq.sv
// Sequential DFP96 packer: converts a 25-digit BCD significand into densely packed
// decimal, one declet per enabled cycle, then assembles sign/combination/exponent.
module dfp96_pack_seq #(
  parameter int NDECL = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic         i_sign,
  input  logic [11:0]  i_exp,
  input  logic [99:0]  i_sig,
  input  logic         i_nan,
  input  logic         i_snan,
  input  logic         i_inf,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [95:0]  o,
  output logic         o_err
);

  localparam int KW = (NDECL > 1) ? $clog2(NDECL) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [KW-1:0] r_k;
  logic          r_sign;
  logic [11:0]   r_exp;
  logic [99:0]   r_sig;
  logic          r_nan;
  logic          r_snan;
  logic          r_inf;
  logic [95:0]   r_o;
  logic          r_valid;
  logic          r_err;

  logic [11:0]   w_trip;
  logic [3:0]    w_d2;
  logic [3:0]    w_d1;
  logic [3:0]    w_d0;
  logic          w_trip_bad;
  logic [9:0]    w_declet;
  logic [3:0]    w_d24;
  logic          w_d24_bad;
  logic [4:0]    w_comb;
  logic          w_exp_oor;
  logic          w_last;

  function automatic logic [3:0] clamp9(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  // IEEE 754-2008 BCD-to-DPD: selection on which of the three digits are 8/9
  function automatic logic [9:0] bcd2dpd(input logic [3:0] h, input logic [3:0] t,
                                         input logic [3:0] u);
    logic [9:0] r;
    case ({h[3], t[3], u[3]})
      3'b000:  r = {h[2:0], t[2:0], 1'b0, u[2:0]};
      3'b001:  r = {h[2:0], t[2:0], 1'b1, 2'b00, u[0]};
      3'b010:  r = {h[2:0], u[2:1], t[0], 1'b1, 2'b01, u[0]};
      3'b100:  r = {u[2:1], h[0], t[2:0], 1'b1, 2'b10, u[0]};
      3'b110:  r = {u[2:1], h[0], 2'b00, t[0], 1'b1, 2'b11, u[0]};
      3'b101:  r = {t[2:1], h[0], 2'b01, t[0], 1'b1, 2'b11, u[0]};
      3'b011:  r = {h[2:0], 2'b10, t[0], 1'b1, 2'b11, u[0]};
      default: r = {2'b00, h[0], 2'b11, t[0], 1'b1, 2'b11, u[0]};
    endcase
    return r;
  endfunction

  always_comb begin
    w_trip     = r_sig[12*r_k +: 12];
    w_trip_bad = (w_trip[11:8] > 4'd9) || (w_trip[7:4] > 4'd9) || (w_trip[3:0] > 4'd9);
    w_d2       = clamp9(w_trip[11:8]);
    w_d1       = clamp9(w_trip[7:4]);
    w_d0       = clamp9(w_trip[3:0]);
    w_declet   = bcd2dpd(w_d2, w_d1, w_d0);
    w_d24_bad  = (r_sig[99:96] > 4'd9);
    w_d24      = clamp9(r_sig[99:96]);
    w_comb     = w_d24[3] ? {2'b11, r_exp[11:10], w_d24[0]} : {r_exp[11:10], w_d24[2:0]};
    w_exp_oor  = (r_exp[11:10] == 2'b11);
    w_last     = (r_k == KW'(NDECL - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_sign  <= 1'b0;
      r_exp   <= '0;
      r_sig   <= '0;
      r_nan   <= 1'b0;
      r_snan  <= 1'b0;
      r_inf   <= 1'b0;
      r_o     <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (ce) begin
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_sign  <= i_sign;
            r_exp   <= i_exp;
            r_sig   <= i_sig;
            r_nan   <= i_nan;
            r_snan  <= i_snan;
            r_inf   <= i_inf;
            r_k     <= '0;
            r_err   <= 1'b0;
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          r_o[10*r_k +: 10] <= w_declet;
          if (w_trip_bad) r_err <= 1'b1;
          if (w_last) begin
            r_state <= S_DONE;
            r_valid <= 1'b1;
            // Infinity wipes the continuation, so the final full write must follow the declet write
            if (r_nan) begin
              r_o[95:80] <= {r_sign, 5'b11111, r_snan, 9'b0};
            end else if (r_inf || w_exp_oor) begin
              r_o <= {r_sign, 5'b11110, 90'b0};
              if (!r_inf) r_err <= 1'b1;
            end else begin
              r_o[95:80] <= {r_sign, w_comb, r_exp[9:0]};
              if (w_d24_bad) r_err <= 1'b1;
            end
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_DONE: begin
          if (o_ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign i_ready = (r_state == S_IDLE);
  assign o_valid = r_valid;
  assign o       = r_o;
  assign o_err   = r_err;

endmodule

// File: tb/tb_dfp96_pack_seq.sv
// Randomized bench for dfp96_pack_seq against a digit-level arithmetic model of DFP96 packing.
module tb_dfp96_pack_seq;

  logic        clk = 1'b0;
  logic        rst, ce, i_valid, i_ready, i_sign, i_nan, i_snan, i_inf;
  logic        o_valid, o_ready, o_err;
  logic [11:0] i_exp;
  logic [99:0] i_sig;
  logic [95:0] o;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [95:0] last_o;

  always #5 clk = ~clk;

  dfp96_pack_seq #(.NDECL(8)) dut (
    .clk(clk), .rst(rst), .ce(ce), .i_valid(i_valid), .i_ready(i_ready),
    .i_sign(i_sign), .i_exp(i_exp), .i_sig(i_sig), .i_nan(i_nan), .i_snan(i_snan),
    .i_inf(i_inf), .o_valid(o_valid), .o_ready(o_ready), .o(o), .o_err(o_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Declet value computed from digit values; a digit of 8/9 contributes only its parity
  function automatic int dpd_ref(input int h, input int t, input int u);
    bit bh, bt, bu;
    bh = (h >= 8); bt = (t >= 8); bu = (u >= 8);
    if (!bh && !bt && !bu) return h*128 + t*16 + u;
    if (!bh && !bt &&  bu) return h*128 + t*16 + 8 + u%2;
    if (!bh &&  bt && !bu) return h*128 + (u/2)*32 + (t%2)*16 + 10 + u%2;
    if ( bh && !bt && !bu) return (u/2)*256 + (h%2)*128 + t*16 + 12 + u%2;
    if ( bh &&  bt && !bu) return (u/2)*256 + (h%2)*128 + (t%2)*16 + 14 + u%2;
    if ( bh && !bt &&  bu) return (t/2)*256 + (h%2)*128 + 32 + (t%2)*16 + 14 + u%2;
    if (!bh &&  bt &&  bu) return h*128 + 64 + (t%2)*16 + 14 + u%2;
    return (h%2)*128 + 96 + (t%2)*16 + 14 + u%2;
  endfunction

  task automatic ref_pack(input logic s, input logic [11:0] e, input logic [99:0] sg,
                          input logic nan, input logic snan, input logic inf,
                          output logic [95:0] ro, output logic rerr);
    int d[25];
    bit bad[25];
    int v, comb, eh;
    for (int i = 0; i < 25; i++) begin
      v = int'(sg[4*i +: 4]);
      bad[i] = (v > 9);
      d[i] = (v > 9) ? 9 : v;
    end
    ro = '0;
    rerr = 1'b0;
    for (int i = 0; i < 24; i++) if (bad[i]) rerr = 1'b1;
    for (int k = 0; k < 8; k++) ro[10*k +: 10] = 10'(dpd_ref(d[3*k+2], d[3*k+1], d[3*k]));
    eh = int'(e[11:10]);
    if (nan) begin
      ro[95:80] = {s, 5'b11111, snan, 9'b0};
    end else if (inf || eh == 3) begin
      ro = {s, 5'b11110, 90'b0};
      if (!inf) rerr = 1'b1;
    end else begin
      if (bad[24]) rerr = 1'b1;
      comb = (d[24] < 8) ? eh*8 + d[24] : 24 + eh*2 + d[24]%2;
      ro[95:80] = {s, 5'(comb), e[9:0]};
    end
  endtask

  function automatic logic [99:0] rand_sig();
    logic [99:0] r;
    for (int i = 0; i < 25; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  task automatic drive_ce(input bit ce_rand);
    ce = ce_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic run_op(input logic s, input logic [11:0] e, input logic [99:0] sg,
                        input logic nan, input logic snan, input logic inf,
                        input bit ce_rand, input int hold);
    logic [95:0] eo, held;
    logic        eerr;
    int          n_ce, guard;
    bit          acc;
    ref_pack(s, e, sg, nan, snan, inf, eo, eerr);
    i_sign = s; i_exp = e; i_sig = sg; i_nan = nan; i_snan = snan; i_inf = inf;
    i_valid = 1'b1; o_ready = 1'b0;
    acc = 1'b0; guard = 0;
    while (!acc && guard < 50) begin
      drive_ce(ce_rand);
      acc = i_ready && ce;
      tick();
      guard++;
    end
    chk("accept", {95'b0, acc}, 96'd1);
    // scramble inputs: the registered copy must be used
    i_valid = 1'b0; i_sign = 1'($urandom); i_exp = 12'($urandom); i_sig = rand_sig();
    i_nan = 1'($urandom); i_snan = 1'($urandom); i_inf = 1'($urandom);
    n_ce = 1; guard = 0;
    while (!o_valid && guard < 200) begin
      drive_ce(ce_rand);
      if (ce) n_ce++;
      tick();
      guard++;
    end
    chk("latency", n_ce, 9);
    chk("o", o, eo);
    chk("o_err", o_err, eerr);
    chk("i_ready_busy", i_ready, 0);
    held = o;
    repeat (hold) begin
      drive_ce(ce_rand);
      tick();
    end
    if (hold > 0) begin
      chk("hold_o", o, held);
      chk("hold_valid", o_valid, 1);
      chk("hold_ready", i_ready, 0);
    end
    o_ready = 1'b1; ce = 1'b1;
    tick();
    chk("release_valid", o_valid, 0);
    chk("release_ready", i_ready, 1);
    o_ready = 1'b0;
    last_o = held;
  endtask

  initial begin
    int          cls, pos;
    logic [99:0] sg;
    logic [11:0] e;
    logic        err_n;

    rst = 1'b1; ce = 1'b0; i_valid = 1'b0; o_ready = 1'b0;
    i_sign = 1'b0; i_exp = '0; i_sig = '0; i_nan = 1'b0; i_snan = 1'b0; i_inf = 1'b0;
    tick(); tick();
    rst = 1'b0; ce = 1'b1;
    chk("rst_ready", i_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_o", o, 0);
    chk("rst_err", o_err, 0);

    run_op(1'b0, 12'h000, 100'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("zero", last_o, 96'h0);
    run_op(1'b0, 12'h000, 100'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    chk("one", last_o, 96'h000000000000000000000001);
    run_op(1'b0, 12'h000, 100'h999, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("dpd999", {86'b0, last_o[9:0]}, 96'h0FF);
    run_op(1'b0, 12'h400, {4'h9, 96'h0}, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("lead9", last_o, 96'h6C0000000000000000000000);
    run_op(1'b1, 12'h123, rand_sig(), 1'b0, 1'b0, 1'b1, 1'b0, 0);
    chk("neg_inf", last_o, 96'hF80000000000000000000000);
    run_op(1'b0, 12'h000, 100'hA, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    err_n = o_err;
    chk("bad_nybble_err", err_n, 1);
    chk("bad_nybble_o", {86'b0, last_o[9:0]}, 96'h009);
    run_op(1'b0, 12'hC05, 100'h12345, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("exp_oor_err", o_err, 1);
    chk("exp_oor_o", last_o, 96'h780000000000000000000000);
    run_op(1'b1, 12'h2AB, rand_sig(), 1'b0, 1'b0, 1'b0, 1'b1, 5);

    // reset during CONV at k=4, with an error already latched from declet 0
    i_sign = 1'b1; i_exp = 12'h0FF; i_sig = 100'hB0; i_nan = 1'b0; i_snan = 1'b0; i_inf = 1'b0;
    i_valid = 1'b1; ce = 1'b1;
    tick();
    i_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_ready", i_ready, 1);
    chk("abort_valid", o_valid, 0);
    chk("abort_o", o, 0);
    chk("abort_err", o_err, 0);
    repeat (12) tick();
    chk("abort_no_valid", o_valid, 0);
    run_op(1'b0, 12'h301, rand_sig(), 1'b0, 1'b0, 1'b0, 1'b0, 2);

    for (int n = 0; n < 150; n++) begin
      cls = $urandom_range(0, 7);
      sg = rand_sig();
      if (cls != 1 && $urandom_range(0, 3) == 0) begin
        pos = $urandom_range(0, 24);
        sg[4*pos +: 4] = 4'($urandom_range(10, 15));
      end
      e = 12'($urandom);
      if (cls == 2) e[11:10] = 2'b11;
      else if (cls >= 3) e[11:10] = 2'($urandom_range(0, 2));
      run_op(1'($urandom), e, sg, cls == 0, 1'($urandom), cls == 1,
             1'($urandom), $urandom_range(0, 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
